bpsk_demod_correlator: RTL and testbench

Coherent BPSK receiver back end. It multiplies each incoming baseband/IF sample by the matching local carrier reference from cosine_lut, integrates the products over one symbol, and emits a hard bit decision. It is the receive-side counterpart of the carrier/modulator path. It sits between the sample source (ADC/filter chain or loopback from the modulator) and the bit sink (framer/UART).

---
 rtl/bpsk_demod_correlator.sv | 165 ++++++++++++++++
 tb/tb_bpsk_demod_correlator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demod_correlator.sv
// bpsk_demod_correlator: coherent BPSK correlator (sample x carrier ref, integrate per symbol, hard decision).
// Optional signed soft output enabled by defining BPSK_DEMOD_SOFT_OUT_EN.
`ifndef FIXDT_16_WIDTH
`define FIXDT_16_WIDTH 16
`endif
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 8
`endif

module cosine_lut #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int READ_PORTS = 1,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [READ_PORTS*AW-1:0]    addr,
    output logic [READ_PORTS*WIDTH-1:0] data
);
    // Entries are round-half-away-from-zero of full-scale cos(2*pi*k/DEPTH), fixed at elaboration.
    function automatic logic signed [WIDTH-1:0] cos_q(input int k);
        real a;
        a = $cos(6.283185307179586 * k / DEPTH) * real'((longint'(1) << (WIDTH - 1)) - 1);
        return WIDTH'($rtoi(a < 0.0 ? a - 0.5 : a + 0.5));
    endfunction

    logic signed [WIDTH-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam logic signed [WIDTH-1:0] V = cos_q(g);
        assign rom[g] = V;
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        assign data[p*WIDTH +: WIDTH] = rom[addr[p*AW +: AW]];
    end
endmodule

module bpsk_demod_correlator #(
    parameter int SAMPLE_WIDTH       = `FIXDT_16_WIDTH,
    parameter int CARRIER_SAMPLES    = `CARRIER_SAMPLES_PER_PERIOD,
    parameter int PERIODS_PER_SYMBOL = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           align,
    input  logic signed [SAMPLE_WIDTH-1:0] s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           bit_out,
    output logic                           bit_valid,
    input  logic                           bit_ready
`ifdef BPSK_DEMOD_SOFT_OUT_EN
    ,
    output logic signed [SAMPLE_WIDTH-1:0] soft_out
`endif
);
    localparam int SPS       = CARRIER_SAMPLES * PERIODS_PER_SYMBOL;
    localparam int CW        = $clog2(SPS);
    localparam int ACC_WIDTH = 2 * SAMPLE_WIDTH + CW;
    localparam int PROD_W    = 2 * SAMPLE_WIDTH;
    localparam int PW        = (CARRIER_SAMPLES > 1) ? $clog2(CARRIER_SAMPLES) : 1;

    logic                    accept;
    logic [PW-1:0]           phase_idx, base_phase, next_phase;
    logic [CW-1:0]           samp_cnt, base_cnt, next_cnt;
    logic signed [SAMPLE_WIDTH-1:0] cos_ref;
    logic [PROD_W-1:0]       s_ext, c_ext;
    logic signed [PROD_W-1:0] prod;
    logic                    p_valid, p_first, p_last;
    logic signed [ACC_WIDTH-1:0] acc, acc_base, acc_sum;
    logic                    step, decide;

    assign s_ready = !(bit_valid && !bit_ready);
    assign accept  = s_valid && s_ready;

    // align restarts the symbol in the same cycle, so an accepted sample becomes index 0
    assign base_phase = align ? '0 : phase_idx;
    assign base_cnt   = align ? '0 : samp_cnt;
    assign next_phase = (base_phase == PW'(CARRIER_SAMPLES - 1)) ? '0 : base_phase + PW'(1);
    assign next_cnt   = (base_cnt == CW'(SPS - 1)) ? '0 : base_cnt + CW'(1);

    cosine_lut #(
        .WIDTH(SAMPLE_WIDTH),
        .DEPTH(CARRIER_SAMPLES),
        .READ_PORTS(1),
        .AW(PW)
    ) u_lut (
        .addr(base_phase),
        .data(cos_ref)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_idx <= '0;
            samp_cnt  <= '0;
        end else if (accept) begin
            phase_idx <= next_phase;
            samp_cnt  <= next_cnt;
        end else if (align) begin
            phase_idx <= '0;
            samp_cnt  <= '0;
        end
    end

    // Low 2W bits of the product of sign-extended operands equal the signed full product
    assign s_ext = {{SAMPLE_WIDTH{s_data[SAMPLE_WIDTH-1]}}, s_data};
    assign c_ext = {{SAMPLE_WIDTH{cos_ref[SAMPLE_WIDTH-1]}}, cos_ref};

    always_ff @(posedge clk) begin
        if (rst) begin
            prod    <= '0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            prod    <= s_ext * c_ext;
            p_valid <= accept;
            p_first <= base_cnt == '0;
            p_last  <= base_cnt == CW'(SPS - 1);
        end
    end

    // A product still in stage 1 on an align edge belongs to the discarded symbol
    assign step     = p_valid && !align;
    assign decide   = step && p_last;
    assign acc_base = p_first ? '0 : acc;
    assign acc_sum  = acc_base + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            if (step)
                acc <= acc_sum;
            if (decide) begin
                bit_out   <= acc_sum[ACC_WIDTH-1];
                bit_valid <= 1'b1;
            end else if (bit_ready) begin
                bit_valid <= 1'b0;
            end
        end
    end

`ifdef BPSK_DEMOD_SOFT_OUT_EN
    localparam int SH = SAMPLE_WIDTH - 1 + CW;
    localparam logic signed [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SMIN = {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0]    acc_sh;
    logic signed [SAMPLE_WIDTH-1:0] soft_next;

    assign acc_sh    = acc_sum >>> SH;
    assign soft_next = (acc_sh > SMAX) ? SMAX[SAMPLE_WIDTH-1:0] :
                       (acc_sh < SMIN) ? SMIN[SAMPLE_WIDTH-1:0] : acc_sh[SAMPLE_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst)
            soft_out <= '0;
        else if (decide)
            soft_out <= soft_next;
    end
`endif
endmodule

// File: tb/tb_bpsk_demod_correlator.sv
// tb_bpsk_demod_correlator: directed plan plus randomized traffic against a symbol-level dot-product model.
module tb_bpsk_demod_correlator;
    localparam int SW  = 16;
    localparam int CS  = 8;
    localparam int PPS = 4;
    localparam int SPS = CS * PPS;

    logic clk = 1'b0;
    logic rst, align, s_valid, s_ready, bit_out, bit_valid, bit_ready;
    logic signed [SW-1:0] s_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;
    int done_cyc = -10;
    int cos_tab [CS];
    int part [$];
    bit expq [$];

    always #5 clk = ~clk;

    bpsk_demod_correlator #(
        .SAMPLE_WIDTH(SW),
        .CARRIER_SAMPLES(CS),
        .PERIODS_PER_SYMBOL(PPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .align(align),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: collect accepted samples per symbol, decide on the sign of their correlation with the carrier
    always @(negedge clk) begin
        longint acc;
        cyc++;
        if (rst) begin
            part.delete();
            expq.delete();
        end else begin
            if (bit_valid && bit_ready) begin
                xfers++;
                if (expq.size() == 0)
                    check("spurious_bit", 1, 0);
                else
                    check("bit_order", bit_out, expq.pop_front());
            end
            if (align) begin
                part.delete();
                if (done_cyc == cyc - 1 && expq.size() > 0)
                    void'(expq.pop_back());
            end
            if (s_valid && s_ready) begin
                part.push_back(int'(s_data));
                if (part.size() == SPS) begin
                    acc = 0;
                    for (int i = 0; i < SPS; i++)
                        acc += longint'(part[i]) * longint'(cos_tab[i % CS]);
                    expq.push_back(acc < 0);
                    part.delete();
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit al);
        int n = 0;
        s_data  = SW'(v);
        s_valid = 1'b1;
        align   = al;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50)
            check("send_timeout", 0, 1);
        tick();
        align = 1'b0;
    endtask

    task automatic send_sym(input int sg);
        for (int k = 0; k < SPS; k++)
            send(sg * cos_tab[k % CS], 1'b0);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int x0, sgn, ph, noise;
        real r;
        for (int k = 0; k < CS; k++) begin
            r = $cos(6.283185307179586 * k / CS) * 32767.0;
            cos_tab[k] = $rtoi(r < 0.0 ? r - 0.5 : r + 0.5);
        end
        rst = 1'b1; align = 1'b0; s_valid = 1'b0; s_data = '0; bit_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_bit_valid", bit_valid, 0);
        check("reset_bit_out", bit_out, 0);
        check("reset_s_ready", s_ready, 1);

        send_sym(1);
        s_valid = 1'b0;
        check("t1_early", bit_valid, 0);
        tick();
        check("t1_latency", bit_valid, 1);
        check("t1_bit", bit_out, 0);
        tick();
        check("t1_drop", bit_valid, 0);

        send_sym(-1);
        s_valid = 1'b0;
        tick();
        check("t2_valid", bit_valid, 1);
        check("t2_bit", bit_out, 1);
        tick();

        send_sym(0);
        s_valid = 1'b0;
        tick();
        check("t3_zero", bit_out, 0);
        tick();
        send_sym(-1);
        s_valid = 1'b0;
        tick();
        check("t3_fullneg", bit_out, 1);
        tick();

        x0 = xfers;
        bit_ready = 1'b0;
        send_sym(1);
        s_valid = 1'b0;
        tick();
        s_valid = 1'b1;
        s_data = SW'(cos_tab[0]);
        check("t4_valid", bit_valid, 1);
        check("t4_sready", s_ready, 0);
        repeat (3) begin
            tick();
            check("t4_hold_bit", bit_out, 0);
            check("t4_hold_valid", bit_valid, 1);
            check("t4_hold_sready", s_ready, 0);
        end
        bit_ready = 1'b1;
        send_sym(1);
        send_sym(-1);
        send_sym(1);
        idle(4);
        check("t4_xfers", xfers - x0, 4);

        x0 = xfers;
        for (int k = 0; k < 5; k++)
            send(cos_tab[k], 1'b0);
        for (int k = 0; k < SPS; k++)
            send(-cos_tab[k % CS], k == 0);
        idle(4);
        check("t5_xfers", xfers - x0, 1);

        for (int k = 0; k < 10; k++)
            send(cos_tab[k % CS], 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6a_valid", bit_valid, 0);
        check("t6a_bit", bit_out, 0);
        check("t6a_sready", s_ready, 1);
        bit_ready = 1'b0;
        send_sym(-1);
        idle(2);
        check("t6_held", bit_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6b_valid", bit_valid, 0);
        check("t6b_bit", bit_out, 0);
        check("t6b_sready", s_ready, 1);
        bit_ready = 1'b1;
        x0 = xfers;
        send_sym(1);
        idle(4);
        check("t6_xfers", xfers - x0, 1);

        sgn = 1;
        ph = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom % 40 == 0)
                sgn = -sgn;
            noise = int'($urandom_range(0, 4000)) - 2000;
            s_data    = ($urandom % 4 == 0) ? SW'($urandom) : SW'(sgn * cos_tab[ph % CS] / 2 + noise);
            s_valid   = $urandom % 10 < 7;
            bit_ready = $urandom % 10 < 6;
            align     = $urandom % 150 == 0;
            rst       = $urandom % 600 == 0;
            ph++;
            tick();
        end
        rst = 1'b0;
        align = 1'b0;
        bit_ready = 1'b1;
        idle(6);
        check("drain_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
